// File: rtl/fp_issue_pkg.sv
// Shared types and RV32F decode helpers for the FP issue controller.
// Source-operand and destination-class decode lives here so the top only handles hazards.
package fp_issue_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [6:0] OPC_OP_FP  = 7'b1010011;
    localparam logic [6:0] OPC_FMADD  = 7'b1000011;
    localparam logic [6:0] OPC_FMSUB  = 7'b1000111;
    localparam logic [6:0] OPC_FNMSUB = 7'b1001011;
    localparam logic [6:0] OPC_FNMADD = 7'b1001111;

    localparam logic [4:0] F5_FSQRT    = 5'b01011;
    localparam logic [4:0] F5_FCMP     = 5'b10100;
    localparam logic [4:0] F5_FCVT_W_S = 5'b11000;
    localparam logic [4:0] F5_FCVT_S_W = 5'b11010;
    localparam logic [4:0] F5_FMV_X_W  = 5'b11100;
    localparam logic [4:0] F5_FMV_W_X  = 5'b11110;

    typedef struct packed {
        logic       is_int;
        logic [4:0] rd;
        logic       tag;
    } retire_entry_t;

    typedef struct packed {
        logic       use_rs1;
        logic       use_rs2;
        logic       use_rs3;
        logic       is_int;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rs3;
    } fp_decode_t;

    function automatic fp_decode_t fp_decode(input logic [31:0] instr);
        fp_decode_t d;
        logic [6:0] opc;
        logic [4:0] f5;
        logic       is_r4;
        logic       is_opfp;
        opc     = instr[6:0];
        f5      = instr[31:27];
        is_r4   = (opc == OPC_FMADD) || (opc == OPC_FMSUB) ||
                  (opc == OPC_FNMSUB) || (opc == OPC_FNMADD);
        is_opfp = (opc == OPC_OP_FP);
        d.rd    = instr[11:7];
        d.rs1   = instr[19:15];
        d.rs2   = instr[24:20];
        d.rs3   = instr[31:27];
        d.use_rs3 = is_r4;
        // Integer-sourced conversions/moves take rs1 from the integer file.
        d.use_rs1 = is_r4 || (is_opfp && (f5 != F5_FCVT_S_W) && (f5 != F5_FMV_W_X));
        d.use_rs2 = is_r4 || (is_opfp && (f5 != F5_FSQRT) && (f5 != F5_FCVT_W_S) &&
                              (f5 != F5_FCVT_S_W) && (f5 != F5_FMV_X_W) &&
                              (f5 != F5_FMV_W_X));
        d.is_int  = is_opfp && ((f5 == F5_FCMP) || (f5 == F5_FCVT_W_S) || (f5 == F5_FMV_X_W));
        return d;
    endfunction

endpackage

// File: rtl/fp_retire_fifo.sv
// In-order retire queue of {is_int, rd, tag} entries for issued FP instructions.
// Power-of-two depth; clear empties the queue synchronously.
module fp_retire_fifo
    import fp_issue_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push,
    input  logic          pop,
    input  logic          clear,
    input  retire_entry_t push_data,
    output retire_entry_t head,
    output logic          full,
    output logic          empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    retire_entry_t   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fp_issue_ctrl.sv
// Core-side FP issue controller: hazard-checked accept, tagged issue, in-order retire
// and FP/int writeback with sticky fflags.
//   state | meaning
//   IDLE  | ready to accept a hazard-free instruction from decode
//   HOLD  | instruction registered, waiting for FPU in_ready
//   FLUSH | one-cycle kill: pulse fpu_flush_o, everything in flight discarded
module fp_issue_ctrl
    import fp_issue_pkg::*;
#(
    parameter int DATAWIDTH       = 32,
    parameter int NUM_FREGS       = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 instr_valid_i,
    output logic                 instr_ready_o,
    input  logic [DATAWIDTH-1:0] instr_i,
    input  logic                 flush_i,
    output logic [DATAWIDTH-1:0] fpu_instr_o,
    output logic                 fpu_in_valid_o,
    input  logic                 fpu_in_ready_i,
    output logic                 fpu_tag_o,
    output logic                 fpu_flush_o,
    input  logic                 fpu_out_valid_i,
    output logic                 fpu_out_ready_o,
    input  logic [DATAWIDTH-1:0] fpu_result_i,
    input  logic [4:0]           fpu_status_i,
    input  logic                 fpu_tag_i,
    output logic                 fwb_en_o,
    output logic [4:0]           fwb_addr_o,
    output logic                 iwb_en_o,
    output logic [4:0]           iwb_addr_o,
    output logic [DATAWIDTH-1:0] wb_data_o,
    output logic [4:0]           fflags_o,
    input  logic                 fflags_clr_i,
    output logic                 tag_err_o
);

    state_t                 state_q, state_d;
    logic [DATAWIDTH-1:0]   instr_q;
    logic                   issue_tag_q;
    logic [NUM_FREGS-1:0]   sb_q, sb_d;
    fp_decode_t             dec;
    retire_entry_t          push_entry;
    retire_entry_t          head;
    logic                   fifo_full, fifo_empty;
    logic                   hazard, ready, accept;
    logic                   issue_hs, out_hs;
    logic                   wb_vld_q, wb_is_int_q;
    logic [4:0]             wb_addr_q;
    logic [DATAWIDTH-1:0]   wb_data_q;
    logic [4:0]             fflags_q;
    logic                   tag_err_q;

    assign dec = fp_decode(instr_i[31:0]);

    // Registered scoreboard only: a writeback in this cycle still blocks.
    assign hazard = (dec.use_rs1 && sb_q[dec.rs1]) ||
                    (dec.use_rs2 && sb_q[dec.rs2]) ||
                    (dec.use_rs3 && sb_q[dec.rs3]) ||
                    (!dec.is_int && sb_q[dec.rd]);

    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        case (state_q)
            IDLE: begin
                ready = !flush_i && !fifo_full && !hazard;
                if (flush_i)                      state_d = FLUSH;
                else if (instr_valid_i && ready)  state_d = HOLD;
            end
            HOLD: begin
                if (flush_i)             state_d = FLUSH;
                else if (fpu_in_ready_i) state_d = IDLE;
            end
            FLUSH:   state_d = flush_i ? FLUSH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign accept          = instr_valid_i && ready;
    assign issue_hs        = (state_q == HOLD) && fpu_in_ready_i && !flush_i;
    assign fpu_out_ready_o = !fifo_empty && (state_q != FLUSH) && !flush_i;
    assign out_hs          = fpu_out_valid_i && fpu_out_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            instr_q     <= '0;
            issue_tag_q <= 1'b0;
        end else begin
            if (accept) instr_q <= instr_i;
            if (flush_i)       issue_tag_q <= 1'b0;
            else if (issue_hs) issue_tag_q <= ~issue_tag_q;
        end
    end

    assign push_entry.is_int = dec.is_int;
    assign push_entry.rd     = dec.rd;
    assign push_entry.tag    = issue_tag_q;

    fp_retire_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_retire_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (accept),
        .pop       (out_hs),
        .clear     (flush_i),
        .push_data (push_entry),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // FP dest bit is released at the end of its writeback pulse cycle.
    always_comb begin
        sb_d = sb_q;
        if (wb_vld_q && !wb_is_int_q) sb_d[wb_addr_q] = 1'b0;
        if (accept && !dec.is_int)    sb_d[dec.rd]    = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)      sb_q <= '0;
        else if (flush_i) sb_q <= '0;
        else              sb_q <= sb_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wb_vld_q    <= 1'b0;
            wb_is_int_q <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
            fflags_q    <= '0;
            tag_err_q   <= 1'b0;
        end else begin
            wb_vld_q <= out_hs;
            if (out_hs) begin
                wb_is_int_q <= head.is_int;
                wb_addr_q   <= head.rd;
                wb_data_q   <= fpu_result_i;
                if (fpu_tag_i != head.tag) tag_err_q <= 1'b1;
            end
            if (fflags_clr_i) fflags_q <= '0;
            else if (out_hs)  fflags_q <= fflags_q | fpu_status_i;
        end
    end

    assign instr_ready_o  = ready;
    assign fpu_instr_o    = instr_q;
    assign fpu_in_valid_o = (state_q == HOLD);
    assign fpu_tag_o      = issue_tag_q;
    assign fpu_flush_o    = (state_q == FLUSH);
    assign fwb_en_o       = wb_vld_q && !wb_is_int_q && !flush_i;
    assign iwb_en_o       = wb_vld_q && wb_is_int_q && !flush_i;
    assign fwb_addr_o     = wb_addr_q;
    assign iwb_addr_o     = wb_addr_q;
    assign wb_data_o      = wb_data_q;
    assign fflags_o       = fflags_q;
    assign tag_err_o      = tag_err_q;

endmodule

// File: tb/tb_fp_issue_ctrl.sv
// Directed bench for fp_issue_ctrl: issue/retire, RAW stall, FIFO-full stall, flush,
// integer writeback with fflags, and tag error with same-cycle fflags clear.
module tb_fp_issue_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        instr_valid_i;
    logic        instr_ready_o;
    logic [31:0] instr_i;
    logic        flush_i;
    logic [31:0] fpu_instr_o;
    logic        fpu_in_valid_o;
    logic        fpu_in_ready_i;
    logic        fpu_tag_o;
    logic        fpu_flush_o;
    logic        fpu_out_valid_i;
    logic        fpu_out_ready_o;
    logic [31:0] fpu_result_i;
    logic [4:0]  fpu_status_i;
    logic        fpu_tag_i;
    logic        fwb_en_o;
    logic [4:0]  fwb_addr_o;
    logic        iwb_en_o;
    logic [4:0]  iwb_addr_o;
    logic [31:0] wb_data_o;
    logic [4:0]  fflags_o;
    logic        fflags_clr_i;
    logic        tag_err_o;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] I_FADD_F3  = 32'h002081D3;
    localparam logic [31:0] I_FMUL_F4  = 32'h10118253;
    localparam logic [31:0] I_FADD_F5  = 32'h002082D3;
    localparam logic [31:0] I_FADD_F6  = 32'h00208353;
    localparam logic [31:0] I_FADD_F7  = 32'h002083D3;
    localparam logic [31:0] I_FADD_F8  = 32'h00130453;  // f8 = f6 + f1
    localparam logic [31:0] I_FEQ_X5   = 32'hA020A2D3;
    localparam logic [31:0] I_FADD_F9  = 32'h002084D3;

    always #5 clk_i = ~clk_i;

    fp_issue_ctrl #(
        .DATAWIDTH       (32),
        .NUM_FREGS       (32),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .instr_valid_i   (instr_valid_i),
        .instr_ready_o   (instr_ready_o),
        .instr_i         (instr_i),
        .flush_i         (flush_i),
        .fpu_instr_o     (fpu_instr_o),
        .fpu_in_valid_o  (fpu_in_valid_o),
        .fpu_in_ready_i  (fpu_in_ready_i),
        .fpu_tag_o       (fpu_tag_o),
        .fpu_flush_o     (fpu_flush_o),
        .fpu_out_valid_i (fpu_out_valid_i),
        .fpu_out_ready_o (fpu_out_ready_o),
        .fpu_result_i    (fpu_result_i),
        .fpu_status_i    (fpu_status_i),
        .fpu_tag_i       (fpu_tag_i),
        .fwb_en_o        (fwb_en_o),
        .fwb_addr_o      (fwb_addr_o),
        .iwb_en_o        (iwb_en_o),
        .iwb_addr_o      (iwb_addr_o),
        .wb_data_o       (wb_data_o),
        .fflags_o        (fflags_o),
        .fflags_clr_i    (fflags_clr_i),
        .tag_err_o       (tag_err_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_ni          = 1'b0;
        instr_valid_i   = 1'b0;
        instr_i         = '0;
        flush_i         = 1'b0;
        fpu_in_ready_i  = 1'b0;
        fpu_out_valid_i = 1'b0;
        fpu_result_i    = '0;
        fpu_status_i    = '0;
        fpu_tag_i       = 1'b0;
        fflags_clr_i    = 1'b0;

        // 1: reset
        repeat (3) @(posedge clk_i);
        #1;
        chk("rst_ready",    instr_ready_o,   1);
        chk("rst_in_valid", fpu_in_valid_o,  0);
        chk("rst_fwb",      fwb_en_o,        0);
        chk("rst_iwb",      iwb_en_o,        0);
        chk("rst_flush",    fpu_flush_o,     0);
        chk("rst_fflags",   fflags_o,        0);
        chk("rst_tag_err",  tag_err_o,       0);
        chk("rst_out_rdy",  fpu_out_ready_o, 0);
        rst_ni         = 1'b1;
        fpu_in_ready_i = 1'b1;
        tick();

        // 2: single FADD f3 issue and retire
        instr_valid_i = 1'b1; instr_i = I_FADD_F3; #1;
        chk("t2_ready", instr_ready_o, 1);
        tick();
        instr_valid_i = 1'b0; #1;
        chk("t2_in_valid",   fpu_in_valid_o, 1);
        chk("t2_fpu_instr",  fpu_instr_o,    I_FADD_F3);
        chk("t2_issue_tag",  fpu_tag_o,      0);
        chk("t2_hold_ready", instr_ready_o,  0);
        tick();
        fpu_out_valid_i = 1'b1; fpu_result_i = 32'h40400000; fpu_status_i = 5'h00; fpu_tag_i = 1'b0; #1;
        chk("t2_in_valid_off", fpu_in_valid_o,  0);
        chk("t2_out_ready",    fpu_out_ready_o, 1);
        tick();
        fpu_out_valid_i = 1'b0; #1;
        chk("t2_fwb_en",   fwb_en_o,   1);
        chk("t2_fwb_addr", fwb_addr_o, 3);
        chk("t2_wb_data",  wb_data_o,  32'h40400000);
        chk("t2_iwb_en",   iwb_en_o,   0);
        tick();
        chk("t2_fwb_pulse_end", fwb_en_o, 0);

        // 3: RAW stall of FMUL f4,f3,f1 behind FADD f3
        instr_valid_i = 1'b1; instr_i = I_FADD_F3; #1;
        chk("t3_first_ready", instr_ready_o, 1);
        tick();
        instr_i = I_FMUL_F4;
        tick();
        chk("t3_raw_stall", instr_ready_o, 0);
        fpu_out_valid_i = 1'b1; fpu_result_i = 32'h11111111; fpu_tag_i = 1'b1;
        tick();
        fpu_out_valid_i = 1'b0; #1;
        chk("t3_fwb_en",      fwb_en_o,      1);
        chk("t3_fwb_addr",    fwb_addr_o,    3);
        chk("t3_stall_in_wb", instr_ready_o, 0);
        tick();
        chk("t3_unblocked", instr_ready_o, 1);
        tick();
        instr_valid_i = 1'b0; #1;
        chk("t3_in_valid",   fpu_in_valid_o, 1);
        chk("t3_fpu_instr",  fpu_instr_o,    I_FMUL_F4);
        chk("t3_issue_tag",  fpu_tag_o,      0);
        tick();
        fpu_out_valid_i = 1'b1; fpu_result_i = 32'h22222222; fpu_tag_i = 1'b0;
        tick();
        fpu_out_valid_i = 1'b0; #1;
        chk("t3_fwb_addr2", fwb_addr_o, 4);
        chk("t3_wb_data2",  wb_data_o,  32'h22222222);
        chk("t3_tag_err",   tag_err_o,  0);

        // 4: FIFO-full stall with three independent instructions
        tick();
        instr_valid_i = 1'b1; instr_i = I_FADD_F5; #1;
        chk("t4_i5_ready", instr_ready_o, 1);
        tick();
        instr_i = I_FADD_F6;
        tick();
        chk("t4_i6_ready", instr_ready_o, 1);
        tick();
        instr_i = I_FADD_F7;
        tick();
        chk("t4_full_stall", instr_ready_o, 0);
        tick();
        chk("t4_full_stall2", instr_ready_o, 0);
        fpu_out_valid_i = 1'b1; fpu_result_i = 32'h33333333; fpu_tag_i = 1'b1; #1;
        chk("t4_out_ready", fpu_out_ready_o, 1);
        tick();
        fpu_out_valid_i = 1'b0; #1;
        chk("t4_fwb_addr",  fwb_addr_o,    5);
        chk("t4_i7_ready",  instr_ready_o, 1);
        tick();
        instr_valid_i = 1'b0; #1;
        chk("t4_i7_instr", fpu_instr_o, I_FADD_F7);
        chk("t4_i7_tag",   fpu_tag_o,   1);

        // 5: flush with f6/f7 in flight, then dependent FADD f8,f6,f1
        tick();
        flush_i = 1'b1; instr_valid_i = 1'b1; instr_i = I_FADD_F8; #1;
        chk("t5_ready_in_flush", instr_ready_o,   0);
        chk("t5_out_rdy_flush",  fpu_out_ready_o, 0);
        tick();
        flush_i = 1'b0;
        fpu_out_valid_i = 1'b1; fpu_result_i = 32'h44444444; fpu_tag_i = 1'b0; #1;
        chk("t5_fpu_flush",     fpu_flush_o,     1);
        chk("t5_flush_ready",   instr_ready_o,   0);
        chk("t5_flush_out_rdy", fpu_out_ready_o, 0);
        chk("t5_flush_in_vld",  fpu_in_valid_o,  0);
        tick();
        fpu_out_valid_i = 1'b0; #1;
        chk("t5_flush_end",  fpu_flush_o,   0);
        chk("t5_no_fwb",     fwb_en_o,      0);
        chk("t5_no_iwb",     iwb_en_o,      0);
        chk("t5_dep_ready",  instr_ready_o, 1);
        tick();
        instr_valid_i = 1'b0; #1;
        chk("t5_in_valid",  fpu_in_valid_o, 1);
        chk("t5_tag_reset", fpu_tag_o,      0);
        tick();
        fpu_out_valid_i = 1'b1; fpu_result_i = 32'h55555555; fpu_tag_i = 1'b0;
        tick();
        fpu_out_valid_i = 1'b0; #1;
        chk("t5_fwb_en",   fwb_en_o,   1);
        chk("t5_fwb_addr", fwb_addr_o, 8);
        chk("t5_tag_err",  tag_err_o,  0);

        // 6: FEQ.S x5 integer writeback and sticky fflags
        tick();
        instr_valid_i = 1'b1; instr_i = I_FEQ_X5; #1;
        chk("t6_ready", instr_ready_o, 1);
        tick();
        instr_valid_i = 1'b0;
        tick();
        fpu_out_valid_i = 1'b1; fpu_result_i = 32'h1; fpu_status_i = 5'h10; fpu_tag_i = 1'b1;
        tick();
        fpu_out_valid_i = 1'b0; fpu_status_i = 5'h00; #1;
        chk("t6_iwb_en",   iwb_en_o,   1);
        chk("t6_iwb_addr", iwb_addr_o, 5);
        chk("t6_wb_data",  wb_data_o,  1);
        chk("t6_fwb_en",   fwb_en_o,   0);
        chk("t6_fflags",   fflags_o,   5'h10);
        tick();
        chk("t6_iwb_off",    iwb_en_o, 0);
        chk("t6_fflags_hold", fflags_o, 5'h10);
        fflags_clr_i = 1'b1;
        tick();
        fflags_clr_i = 1'b0; #1;
        chk("t6_fflags_clr", fflags_o, 0);

        // 7: wrong return tag with same-cycle fflags clear
        tick();
        instr_valid_i = 1'b1; instr_i = I_FADD_F9;
        tick();
        instr_valid_i = 1'b0; #1;
        chk("t7_issue_tag", fpu_tag_o, 0);
        tick();
        fpu_out_valid_i = 1'b1; fpu_result_i = 32'h66666666; fpu_status_i = 5'h01;
        fpu_tag_i = 1'b1; fflags_clr_i = 1'b1;
        tick();
        fpu_out_valid_i = 1'b0; fflags_clr_i = 1'b0; fpu_status_i = 5'h00; #1;
        chk("t7_fwb_en",    fwb_en_o,   1);
        chk("t7_fwb_addr",  fwb_addr_o, 9);
        chk("t7_wb_data",   wb_data_o,  32'h66666666);
        chk("t7_tag_err",   tag_err_o,  1);
        chk("t7_clr_wins",  fflags_o,   0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
